cache_subsystem_wb: RTL and testbench

CACHE_SUBSYSTEM_WB -- requirements
Module: cache_subsystem_wb

---
 rtl/cache_subsystem_wb.sv | 195 +++++++++++++++++++
 tb/tb_cache_subsystem_wb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_subsystem_wb.sv
// Write-back, write-allocate cache (direct-mapped or 2-way) with per-set LRU and whole-cache flush.
// Hits complete with zero wait states. Misses and flushes stall the processor until memory acknowledges.
module cache_subsystem_wb #(
   parameter  int WAYS         = 2,
   parameter  int INDEX_WIDTH  = 6,
   parameter  int OFFSET_WIDTH = 4,
   parameter  int ADDR_WIDTH   = 32,
   localparam int WORDS        = 2 ** (OFFSET_WIDTH - 2),
   localparam int BLOCK_WIDTH  = 32 * WORDS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic                   read,
   input  logic                   write,
   input  logic [31:0]            wdata,
   input  logic                   flush,
   output logic [31:0]            rdata,
   output logic                   stall,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic [BLOCK_WIDTH-1:0] mem_wblock,
   input  logic [BLOCK_WIDTH-1:0] mem_rblock,
   input  logic                   mem_ack
);
   localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int SETS       = 2 ** INDEX_WIDTH;
   localparam int WORD_WIDTH = OFFSET_WIDTH - 2;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FLUSH} state_t;

   state_t                    state_q, state_d;
   logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
   logic [SETS-1:0][WAYS-1:0] dirty_q, dirty_d;
   logic [SETS-1:0]           lru_q, lru_d;
   logic                      victim_q, victim_d;
   logic [INDEX_WIDTH-1:0]    flush_set_q, flush_set_d;
   logic                      flush_way_q, flush_way_d;

   logic [TAG_WIDTH-1:0]      tag_q  [WAYS][SETS];
   logic [BLOCK_WIDTH-1:0]    line_q [WAYS][SETS];
   logic [BLOCK_WIDTH-1:0]    line_d;
   logic                      line_we;
   logic                      line_way;
   logic                      tag_we;

   logic [TAG_WIDTH-1:0]      req_tag;
   logic [INDEX_WIDTH-1:0]    req_idx;
   logic [WORD_WIDTH-1:0]     req_word;
   logic                      addr_unused;
   logic                      hit, hit_way, victim;
   logic                      flush_dirty, flush_advance, flush_last_way;

   assign req_tag     = addr[ADDR_WIDTH-1 -: TAG_WIDTH];
   assign req_idx     = addr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign req_word    = addr[OFFSET_WIDTH-1:2];
   assign addr_unused = ^addr[1:0];

   // Lookup of the indexed set; the victim is the first invalid way, else the LRU way.
   always_comb begin
      hit     = 1'b0;
      hit_way = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = 1'(w);
         end
      end
      victim = 1'b0;
      if (WAYS == 2 && valid_q[req_idx][0])
         victim = valid_q[req_idx][WAYS-1] ? lru_q[req_idx] : 1'b1;
   end

   assign flush_last_way = (WAYS == 1) || flush_way_q;
   assign flush_dirty    = valid_q[flush_set_q][flush_way_q] && dirty_q[flush_set_q][flush_way_q];

   // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      dirty_d       = dirty_q;
      lru_d         = lru_q;
      victim_d      = victim_q;
      flush_set_d   = flush_set_q;
      flush_way_d   = flush_way_q;
      line_we       = 1'b0;
      line_way      = hit_way;
      line_d        = line_q[hit_way][req_idx];
      tag_we        = 1'b0;
      flush_advance = 1'b0;
      stall         = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wblock    = line_q[victim_q][req_idx];
      rdata         = line_q[hit_way][req_idx][{req_word, 5'd0} +: 32];

      case (state_q)
         IDLE: begin
            if (flush) begin
               stall   = 1'b1;
               state_d = FLUSH;
            end else if (read || write) begin
               if (hit) begin
                  if (WAYS == 2) lru_d[req_idx] = ~hit_way;
                  if (write) begin
                     line_we                          = 1'b1;
                     line_d[{req_word, 5'd0} +: 32]   = wdata;
                     dirty_d[req_idx][hit_way]        = 1'b1;
                  end
               end else begin
                  stall    = 1'b1;
                  victim_d = victim;
                  state_d  = (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? WRITEBACK : ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {tag_q[victim_q][req_idx], req_idx, {OFFSET_WIDTH{1'b0}}};
            if (mem_ack) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_idx, {OFFSET_WIDTH{1'b0}}};
            if (mem_ack) begin
               line_we                    = 1'b1;
               line_way                   = victim_q;
               line_d                     = mem_rblock;
               tag_we                     = 1'b1;
               valid_d[req_idx][victim_q] = 1'b1;
               dirty_d[req_idx][victim_q] = 1'b0;
               state_d                    = IDLE;
            end
         end
         FLUSH: begin
            stall      = 1'b1;
            mem_wblock = line_q[flush_way_q][flush_set_q];
            if (flush_dirty) begin
               mem_req       = 1'b1;
               mem_we        = 1'b1;
               mem_addr      = {tag_q[flush_way_q][flush_set_q], flush_set_q, {OFFSET_WIDTH{1'b0}}};
               flush_advance = mem_ack;
            end else begin
               flush_advance = 1'b1;
            end
            if (flush_advance) begin
               valid_d[flush_set_q][flush_way_q] = 1'b0;
               dirty_d[flush_set_q][flush_way_q] = 1'b0;
               lru_d[flush_set_q]                = 1'b0;
               if (flush_last_way) begin
                  flush_way_d = 1'b0;
                  flush_set_d = flush_set_q + INDEX_WIDTH'(1);
                  if (flush_set_q == INDEX_WIDTH'(SETS - 1)) state_d = IDLE;
               end else begin
                  flush_way_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         lru_q       <= '0;
         victim_q    <= 1'b0;
         flush_set_q <= '0;
         flush_way_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         lru_q       <= lru_d;
         victim_q    <= victim_d;
         flush_set_q <= flush_set_d;
         flush_way_q <= flush_way_d;
      end
   end

   // NOTE: tag and line storage is left out of reset; its contents only matter once the valid bit is set.
   always_ff @(posedge clk) begin
      if (line_we) line_q[line_way][req_idx] <= line_d;
      if (tag_we)  tag_q[victim_q][req_idx]  <= req_tag;
   end

endmodule

// File: tb/tb_cache_subsystem_wb.sv
// Directed bench for cache_subsystem_wb: a transparent-memory reference model checks every completed
// load, a memory responder checks bus handshakes, and literal expectations pin the directed scenarios.
module tb_cache_subsystem_wb;
   localparam int AW    = 32;
   localparam int WORDS = 4;
   localparam int BW    = 32 * WORDS;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [31:0]   wdata = '0;
   logic          flush = 1'b0;
   logic [31:0]   rdata;
   logic          stall;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_wblock;
   logic [BW-1:0] mem_rblock;
   logic          mem_ack;

   int total = 0;
   int bad   = 0;

   cache_subsystem_wb dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .read       (read),
      .write      (write),
      .wdata      (wdata),
      .flush      (flush),
      .rdata      (rdata),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wblock (mem_wblock),
      .mem_rblock (mem_rblock),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: backing memory as the bench's memory holds it, and the architectural view a processor must see.
   logic [31:0] backing [logic [31:0]];
   logic [31:0] arch    [logic [31:0]];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return ~a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] backing_rd(input logic [31:0] a);
      return backing.exists(a) ? backing[a] : init_word(a);
   endfunction

   function automatic logic [31:0] arch_rd(input logic [31:0] a);
      return arch.exists(a) ? arch[a] : init_word(a);
   endfunction

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] w0;
   } txn_t;

   txn_t log_q[$];

   function automatic txn_t log_at(input int i);
      txn_t t;
      t = '{1'b0, 32'hFFFF_FFFF, 32'h0};
      if (i >= 0 && i < log_q.size()) t = log_q[i];
      return t;
   endfunction

   // Memory responder: acks each request after ack_delay cycles and checks the request holds meanwhile.
   int            ack_delay = 0;
   logic          r_pend;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [BW-1:0] r_wb;
   int            r_wait;

   initial begin
      mem_ack    = 1'b0;
      mem_rblock = '0;
      r_pend     = 1'b0;
      r_wait     = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mem_ack = 1'b0;
            r_pend  = 1'b0;
         end else begin
            if (mem_ack) begin
               mem_ack = 1'b0;
               r_pend  = 1'b0;
            end
            if (!r_pend && mem_req) begin
               r_pend = 1'b1;
               r_we   = mem_we;
               r_addr = mem_addr;
               r_wb   = mem_wblock;
               r_wait = ack_delay;
               check("mem_start", {mem_addr[3:0], stall}, {4'h0, 1'b1});
            end else if (r_pend) begin
               check("mem_hold", {mem_req, mem_we, stall, mem_addr}, {1'b1, r_we, 1'b1, r_addr});
            end
            if (r_pend && !mem_ack) begin
               if (r_wait == 0) begin
                  mem_ack = 1'b1;
                  for (int w = 0; w < WORDS; w++) begin
                     if (r_we) backing[r_addr + 32'(4 * w)] = r_wb[32*w +: 32];
                     else      mem_rblock[32*w +: 32] = backing_rd(r_addr + 32'(4 * w));
                  end
                  log_q.push_back('{r_we, r_addr, r_wb[31:0]});
               end else begin
                  r_wait--;
               end
            end
         end
      end
   end

   // Compare process: every completed load must return the architectural value; completed stores update it.
   logic [31:0] wa_c;
   initial begin
      forever begin
         @(negedge clk);
         if (rst && !stall && (read || write)) begin
            wa_c = {addr[31:2], 2'b00};
            if (write) arch[wa_c] = wdata;
            else       check("rdata_model", rdata, arch_rd(wa_c));
         end
      end
   end

   logic        acc_first_stall;
   int          acc_cycles;
   logic [31:0] acc_rdata;

   task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd);
      int n;
      @(posedge clk);
      #1;
      addr  = a;
      read  = rd;
      write = wr;
      wdata = wd;
      @(negedge clk);
      acc_first_stall = stall;
      n = 0;
      while (stall && n < 500) begin
         @(negedge clk);
         n++;
      end
      acc_cycles = n;
      acc_rdata  = rdata;
      check("access_done", stall, 1'b0);
      @(posedge clk);
      #1;
      read  = 1'b0;
      write = 1'b0;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int   base;
   int   n;
   int   mism;
   int   hits_1000;
   txn_t t;

   initial begin
      backing[32'h44] = 32'hA5A5_A5A5;
      arch[32'h44]    = 32'hA5A5_A5A5;

      // Reset state and idle behaviour
      repeat (3) @(negedge clk);
      check("reset_outputs", {stall, mem_req, mem_we}, 3'b000);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_quiet", {stall, mem_req}, 2'b00);

      // Cold read miss, allocate, then zero-wait hit
      base = log_q.size();
      access(32'h40, 1'b1, 1'b0, 32'h0);
      check("cold_first_stall", acc_first_stall, 1'b1);
      check("cold_cycles", acc_cycles, 2);
      t = log_at(base);
      check("cold_fetch", {t.we, t.addr}, {1'b0, 32'h40});
      access(32'h44, 1'b1, 1'b0, 32'h0);
      check("word1_hit_stall", acc_first_stall, 1'b0);
      check("word1_rdata", acc_rdata, 32'hA5A5_A5A5);

      // Write hit, then two misses evict the dirty LRU line
      access(32'h40, 1'b0, 1'b1, 32'hDEAD_BEEF);
      check("write_hit_stall", acc_first_stall, 1'b0);
      base = log_q.size();
      access(32'h440, 1'b1, 1'b0, 32'h0);
      access(32'h840, 1'b1, 1'b0, 32'h0);
      check("evict_txn_count", log_q.size() - base, 3);
      t = log_at(base + 1);
      check("evict_wb_addr", {t.we, t.addr}, {1'b1, 32'h40});
      check("evict_wb_data", t.w0, 32'hDEAD_BEEF);
      t = log_at(base + 2);
      check("evict_fetch", {t.we, t.addr}, {1'b0, 32'h840});
      access(32'h40, 1'b1, 1'b0, 32'h0);
      check("refetch_rdata", acc_rdata, 32'hDEAD_BEEF);

      // LRU: the recently used line survives a conflict miss
      access(32'h50, 1'b1, 1'b0, 32'h0);
      access(32'h450, 1'b1, 1'b0, 32'h0);
      access(32'h50, 1'b1, 1'b0, 32'h0);
      check("lru_hit_stall", acc_first_stall, 1'b0);
      base = log_q.size();
      access(32'h850, 1'b1, 1'b0, 32'h0);
      check("lru_txn_count", log_q.size() - base, 1);
      t = log_at(base);
      check("lru_fetch", {t.we, t.addr}, {1'b0, 32'h850});
      access(32'h50, 1'b1, 1'b0, 32'h0);
      check("lru_keep_hit", acc_first_stall, 1'b0);
      access(32'h450, 1'b1, 1'b0, 32'h0);
      check("lru_evicted_miss", acc_first_stall, 1'b1);

      // Flush writes back exactly the two dirty lines, in index order
      access(32'h10, 1'b0, 1'b1, 32'h0101_0101);
      access(32'h20, 1'b0, 1'b1, 32'h0202_0202);
      base = log_q.size();
      @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flush_stall_now", stall, 1'b1);
      @(posedge clk);
      #1 flush = 1'b0;
      n = 0;
      @(negedge clk);
      while (stall && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("flush_done", {stall, mem_req}, 2'b00);
      check("flush_txn_count", log_q.size() - base, 2);
      t = log_at(base);
      check("flush_wb0_addr", {t.we, t.addr}, {1'b1, 32'h10});
      check("flush_wb0_data", t.w0, 32'h0101_0101);
      t = log_at(base + 1);
      check("flush_wb1_addr", {t.we, t.addr}, {1'b1, 32'h20});
      check("flush_wb1_data", t.w0, 32'h0202_0202);
      mism = 0;
      foreach (arch[k]) if (backing_rd(k) !== arch[k]) mism++;
      check("flush_coherent", mism, 0);
      access(32'h10, 1'b1, 1'b0, 32'h0);
      check("after_flush_miss", acc_first_stall, 1'b1);
      check("after_flush_rdata", acc_rdata, 32'h0101_0101);

      // Simultaneous read and write behaves as a write
      access(32'h50, 1'b1, 1'b1, 32'h1111_2222);
      check("rw_miss_stall", acc_first_stall, 1'b1);
      access(32'h50, 1'b1, 1'b0, 32'h0);
      check("rw_hit_stall", acc_first_stall, 1'b0);
      check("rw_rdata", acc_rdata, 32'h1111_2222);

      // Slow memory with reset in the middle of the allocate
      ack_delay = 20;
      base = log_q.size();
      @(posedge clk);
      #1;
      addr = 32'h1000;
      read = 1'b1;
      n = 0;
      @(negedge clk);
      while (!mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("slow_req_seen", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h1000});
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1 check("reset_kills_req", {mem_req, mem_we}, 2'b00);
      read = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      check("slow_no_completion", log_q.size() - base, 0);
      arch      = backing;
      ack_delay = 0;
      access(32'h1000, 1'b1, 1'b0, 32'h0);
      check("post_reset_miss_1000", acc_first_stall, 1'b1);
      access(32'h40, 1'b1, 1'b0, 32'h0);
      check("post_reset_miss_40", acc_first_stall, 1'b1);
      hits_1000 = 0;
      foreach (log_q[i]) if (log_q[i].addr == 32'h1000) hits_1000++;
      check("fetch_1000_once", hits_1000, 1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
